// File: rtl/result_collector.sv
// result_collector
//   Captures result words from the upstream data interface into a FIFO and
//   pairs them with the expected frame length. Each frame goes to the host on
//   a valid/ready stream as a header word (the count) followed by exactly that
//   many result words. Upstream has no backpressure, so the block raises an
//   early almost_full warning and keeps sticky error flags.
//
//   Optional feature macro: RESULT_CHECKSUM_EN
//     When it is defined, a TRAILER word follows the body. The trailer carries
//     the XOR of all body words, and m_last moves onto the trailer.
//
// Ports
//   clk             rising-edge clock
//   clear           asynchronous active-low reset
//   enable          ingress enable for results and counts (egress always runs)
//   res_data/valid  result word from upstream
//   exp_count/valid expected word count for the next frame
//   m_data/valid/ready/last  egress stream to host
//   almost_full     registered, free entries <= AFULL_MARGIN
//   overflow        sticky, a result was dropped on a full FIFO
//   frame_error     sticky, a count arrived while another was pending
//   busy            registered, FSM not idle or a count pending
//
// state   | meaning
// IDLE    | waiting for a pending count
// HEADER  | presenting the count word
// BODY    | streaming FIFO words until remaining reaches zero
// TRAILER | presenting the XOR checksum (RESULT_CHECKSUM_EN only)
module result_collector #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] res_data,
  input  logic        res_valid,
  input  logic [31:0] exp_count,
  input  logic        exp_count_valid,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        almost_full,
  output logic        overflow,
  output logic        frame_error,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    BODY    = 2'd2,
    TRAILER = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, level_nx;
  logic        full, empty, push, pop, drop;
  logic [31:0] head;
  logic        pend_v, pend_v_nx;
  logic [31:0] pend_cnt;
  logic        cnt_in, take_cnt, cnt_load, cnt_err;
  logic [31:0] remaining, remaining_nx;
  logic        afull_nx, busy_nx;
`ifdef RESULT_CHECKSUM_EN
  logic [31:0] csum;
`endif

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = enable && res_valid && (!full || pop);
  assign drop = enable && res_valid && !push;

  assign wr_ptr_nx = push ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_ptr_nx = pop  ? rd_ptr + PTR_ONE : rd_ptr;
  assign level_nx  = wr_ptr_nx - rd_ptr_nx;
  assign afull_nx  = (32'(DEPTH) - 32'(level_nx)) <= 32'(AFULL_MARGIN);

  // If the FSM consumes the pending count in the same cycle that a new count
  // arrives, the slot is being vacated, so the new count is accepted.
  assign cnt_in   = enable && exp_count_valid;
  assign cnt_load = cnt_in && (!pend_v || take_cnt);
  assign cnt_err  = cnt_in && pend_v && !take_cnt;

  always_comb begin
    pend_v_nx = pend_v;
    if (take_cnt) pend_v_nx = 1'b0;
    if (cnt_load) pend_v_nx = 1'b1;
  end

  assign busy_nx = (state_nx != IDLE) || pend_v_nx;

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    m_valid      = 1'b0;
    m_data       = '0;
    m_last       = 1'b0;
    pop          = 1'b0;
    take_cnt     = 1'b0;
    case (state)
      IDLE: begin
        if (pend_v) begin
          take_cnt     = 1'b1;
          remaining_nx = pend_cnt;
          state_nx     = HEADER;
        end
      end
      HEADER: begin
        m_valid = 1'b1;
        m_data  = remaining;
`ifdef RESULT_CHECKSUM_EN
        if (m_ready) state_nx = (remaining == 32'd0) ? TRAILER : BODY;
`else
        m_last = (remaining == 32'd0);
        if (m_ready) state_nx = (remaining == 32'd0) ? IDLE : BODY;
`endif
      end
      BODY: begin
        m_valid = !empty;
        m_data  = head;
`ifndef RESULT_CHECKSUM_EN
        m_last = (remaining == 32'd1);
`endif
        if (!empty && m_ready) begin
          pop          = 1'b1;
          remaining_nx = remaining - 32'd1;
`ifdef RESULT_CHECKSUM_EN
          if (remaining == 32'd1) state_nx = TRAILER;
`else
          if (remaining == 32'd1) state_nx = IDLE;
`endif
        end
      end
`ifdef RESULT_CHECKSUM_EN
      TRAILER: begin
        m_valid = 1'b1;
        m_data  = csum;
        m_last  = 1'b1;
        if (m_ready) state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= res_data;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pend_v      <= 1'b0;
      pend_cnt    <= '0;
      remaining   <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      wr_ptr      <= wr_ptr_nx;
      rd_ptr      <= rd_ptr_nx;
      pend_v      <= pend_v_nx;
      remaining   <= remaining_nx;
      almost_full <= afull_nx;
      busy        <= busy_nx;
      if (cnt_load) pend_cnt <= exp_count;
      if (drop) overflow <= 1'b1;
      if (cnt_err) frame_error <= 1'b1;
    end
  end

`ifdef RESULT_CHECKSUM_EN
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      csum <= '0;
    end else if (take_cnt) begin
      csum <= '0;
    end else if (pop) begin
      csum <= csum ^ head;
    end
  end
`endif

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;
  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] res_data = '0;
  logic        res_valid = 1'b0;
  logic [31:0] exp_count = '0;
  logic        exp_count_valid = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        almost_full, overflow, frame_error, busy;

  int tests = 0;
  int fails = 0;

  result_collector #(.DEPTH(16), .AFULL_MARGIN(4)) dut (
    .clk(clk), .clear(clear), .enable(enable),
    .res_data(res_data), .res_valid(res_valid),
    .exp_count(exp_count), .exp_count_valid(exp_count_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .almost_full(almost_full), .overflow(overflow),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for m_valid, checks the word, then accepts it.
  task automatic recv(input string tag, input logic [31:0] d, input logic l);
    int n = 0;
    while (!m_valid && n < 50) begin
      step();
      n++;
    end
    check({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
    check({tag, "_data"}, m_data, d);
    check({tag, "_last"}, {31'd0, m_last}, {31'd0, l});
    m_ready = 1'b1;
    step();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_afull", {31'd0, almost_full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_error", {31'd0, frame_error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    #1 clear = 1'b1;
    step();

    // Count 3 then results A, B, C with m_ready high
    enable = 1'b1; m_ready = 1'b1;
    exp_count = 32'd3; exp_count_valid = 1'b1;
    step();
    check("t1_busy_pend", {31'd0, busy}, 32'd1);
    check("t1_no_valid_yet", {31'd0, m_valid}, 32'd0);
    exp_count_valid = 1'b0;
    res_data = 32'hA; res_valid = 1'b1;
    step();
    check("t1_hdr_valid", {31'd0, m_valid}, 32'd1);
    check("t1_hdr_data", m_data, 32'd3);
    check("t1_hdr_last", {31'd0, m_last}, 32'd0);
    res_data = 32'hB;
    step();
    check("t1_w0_data", m_data, 32'hA);
    check("t1_w0_last", {31'd0, m_last}, 32'd0);
    res_data = 32'hC;
    step();
    check("t1_w1_data", m_data, 32'hB);
    check("t1_w1_last", {31'd0, m_last}, 32'd0);
    res_valid = 1'b0;
    step();
    check("t1_w2_data", m_data, 32'hC);
    check("t1_w2_last", {31'd0, m_last}, 32'd1);
    step();
    check("t1_done_valid", {31'd0, m_valid}, 32'd0);
    check("t1_done_busy", {31'd0, busy}, 32'd0);

    // Count 0: single header word with m_last
    exp_count = 32'd0; exp_count_valid = 1'b1;
    step();
    exp_count_valid = 1'b0;
    step();
    check("t2_hdr_valid", {31'd0, m_valid}, 32'd1);
    check("t2_hdr_data", m_data, 32'd0);
    check("t2_hdr_last", {31'd0, m_last}, 32'd1);
    step();
    check("t2_idle_valid", {31'd0, m_valid}, 32'd0);
    check("t2_idle_busy", {31'd0, busy}, 32'd0);

    // Fill with m_ready low: almost_full at 12 entries, 17th word dropped
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      res_data = 32'h100 + 32'(i); res_valid = 1'b1;
      step();
      if (i == 10) check("t3_afull_at11", {31'd0, almost_full}, 32'd0);
      if (i == 11) check("t3_afull_at12", {31'd0, almost_full}, 32'd1);
      if (i == 15) check("t3_ovf_at16", {31'd0, overflow}, 32'd0);
      if (i == 16) check("t3_ovf_at17", {31'd0, overflow}, 32'd1);
    end
    res_valid = 1'b0;
    exp_count = 32'd16; exp_count_valid = 1'b1;
    step();
    exp_count_valid = 1'b0;
    recv("t3_hdr", 32'd16, 1'b0);
    for (int i = 0; i < 16; i++) recv($sformatf("t3_w%0d", i), 32'h100 + 32'(i), i == 15);
    check("t3_afull_after", {31'd0, almost_full}, 32'd0);
    check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Results before count, then a 5-cycle stall on the first body word
    m_ready = 1'b0;
    res_data = 32'h1; res_valid = 1'b1; step();
    res_data = 32'h2; step();
    res_valid = 1'b0;
    exp_count = 32'd2; exp_count_valid = 1'b1; step();
    exp_count_valid = 1'b0; step();
    check("t4_hdr_data", m_data, 32'd2);
    m_ready = 1'b1; step();
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_stall%0d_valid", k), {31'd0, m_valid}, 32'd1);
      check($sformatf("t4_stall%0d_data", k), m_data, 32'h1);
      step();
    end
    recv("t4_w0", 32'h1, 1'b0);
    recv("t4_w1", 32'h2, 1'b1);
    check("t4_done_valid", {31'd0, m_valid}, 32'd0);

    // Count 4 pending while a frame is stalled; count 5 rejected
    m_ready = 1'b0;
    exp_count = 32'd1; exp_count_valid = 1'b1; step();
    exp_count_valid = 1'b0; step();
    exp_count = 32'd4; exp_count_valid = 1'b1; step();
    check("t5_ferr_before", {31'd0, frame_error}, 32'd0);
    exp_count = 32'd5; step();
    exp_count_valid = 1'b0;
    check("t5_ferr_set", {31'd0, frame_error}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      res_data = 32'h31 + 32'(i); res_valid = 1'b1;
      step();
    end
    res_valid = 1'b0;
    recv("t5_hdrA", 32'd1, 1'b0);
    recv("t5_a0", 32'h31, 1'b1);
    recv("t5_hdrB", 32'd4, 1'b0);
    recv("t5_b0", 32'h32, 1'b0);
    recv("t5_b1", 32'h33, 1'b0);
    recv("t5_b2", 32'h34, 1'b0);
    recv("t5_b3", 32'h35, 1'b1);
    step(); step(); step();
    check("t5_no_frame5", {31'd0, m_valid}, 32'd0);
    check("t5_idle_busy", {31'd0, busy}, 32'd0);

    // Reset mid-body after 2 of 4 words
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_data = 32'h21 + 32'(i); res_valid = 1'b1;
      step();
    end
    res_valid = 1'b0;
    exp_count = 32'd4; exp_count_valid = 1'b1; step();
    exp_count_valid = 1'b0;
    recv("t6_hdr", 32'd4, 1'b0);
    recv("t6_w0", 32'h21, 1'b0);
    recv("t6_w1", 32'h22, 1'b0);
    check("t6_pre_clear", m_data, 32'h23);
    #2 clear = 1'b0;
    #1;
    check("t6_clr_valid", {31'd0, m_valid}, 32'd0);
    check("t6_clr_data", m_data, 32'd0);
    check("t6_clr_last", {31'd0, m_last}, 32'd0);
    check("t6_clr_ovf", {31'd0, overflow}, 32'd0);
    check("t6_clr_ferr", {31'd0, frame_error}, 32'd0);
    check("t6_clr_busy", {31'd0, busy}, 32'd0);
    check("t6_clr_afull", {31'd0, almost_full}, 32'd0);
    #1 clear = 1'b1;
    step();
    check("t6_post_valid", {31'd0, m_valid}, 32'd0);
    exp_count = 32'd1; exp_count_valid = 1'b1;
    res_data = 32'h55; res_valid = 1'b1;
    step();
    exp_count_valid = 1'b0; res_valid = 1'b0;
    recv("t6_new_hdr", 32'd1, 1'b0);
    recv("t6_new_w0", 32'h55, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/result_collector.md
# result_collector

Downstream stage of the data interface. It captures each result word produced under `y_valid`, buffers the words in a FIFO, and pairs them with the expected output length reported under `out_count_valid`. It then emits framed packets to the host over a valid/ready stream: a header word carrying the count, followed by exactly that many result words. Because the upstream stage has no backpressure, the block also provides an early-warning `almost_full` and sticky error flags.

## Interface
- `DEPTH`, 16: FIFO depth in 32-bit words; power of two, ≥4.
- `AFULL_MARGIN`, 4: `almost_full` asserts when free entries ≤ this value.

- `clk`  input  1  global clock, rising edge.
- `clear`  input  1  asynchronous active-low reset.
- `enable`  input  1  ingress enable; egress runs regardless.
- `res_data`  input  32  result word (upstream `data_out`).
- `res_valid`  input  1  result word valid (upstream `y_valid`).
- `exp_count`  input  32  expected result words for the next frame (upstream `out_count`).
- `exp_count_valid`  input  1  `exp_count` valid.
- `m_data`  output  32  egress word.
- `m_valid`  output  1  egress word valid.
- `m_ready`  input  1  host accepts the egress word.
- `m_last`  output  1  final word of the frame.
- `almost_full`  output  1  FIFO free entries ≤ `AFULL_MARGIN`.
- `overflow`  output  1  sticky: a result was dropped because the FIFO was full.
- `frame_error`  output  1  sticky: a count arrived while one was already pending.
- `busy`  output  1  FSM not IDLE, or a count is pending.

## Operation
- **Ingress**
  - Push when `enable && res_valid` and (not full, or a pop occurs in the same cycle).
  - Otherwise the word is dropped and `overflow` is set.
  - Results may arrive before their count; they wait in the FIFO.
- **Count latch**
  - On `enable && exp_count_valid`, load `pend_cnt` and set `pend_v`.
  - If `pend_v` is already 1, the new count is ignored and `frame_error` is set.
  - FSM consumption of `pend_v` and a new count arriving in the same cycle: the new count is accepted.
- **FSM states: IDLE, HEADER, BODY**
  - IDLE: if `pend_v`, copy `pend_cnt` into `remaining`, clear `pend_v`, go to HEADER.
  - HEADER:
    - Drive `m_valid=1`, `m_data=remaining`, `m_last=(remaining==0)`.
    - On `m_ready`: go to IDLE if `remaining==0`, else go to BODY.
  - BODY:
    - Drive `m_valid=!empty`, `m_data=FIFO head` (first-word fall-through), `m_last=(remaining==1)`.
    - On handshake: pop and decrement `remaining`. If `remaining` was 1, go to IDLE.
- **Handshake rules**
  - Transfer occurs when `m_valid && m_ready` on a rising edge.
  - While `m_valid=1` and `m_ready=0`, `m_data`/`m_last` hold stable.
  - `m_valid` never drops without a transfer.
- **Arithmetic**
  - Pointers are `log2(DEPTH)+1` bits, wrapping at 2·DEPTH.
  - Full when the MSBs differ and the rest are equal; empty when the pointers are equal.
  - `remaining` is 32-bit unsigned; no other overflow cases exist.
- **Flags**
  - `overflow` and `frame_error` clear only on reset.
  - Stray results beyond a frame's count stay in the FIFO and are consumed by the next frame.

## Timing
- Reset (`clear=0`, asynchronous):
  - Pointers, `pend_v`, `remaining` = 0; FSM = IDLE.
  - All outputs 0: `m_data`, `m_valid`, `m_last`, `almost_full`, `overflow`, `frame_error`, `busy`.
- Reset mid-frame discards the FIFO contents and the partial frame; the host sees `m_valid` drop asynchronously.
- Count latency:
  - Count sampled at edge N → `pend_v` at N.
  - FSM enters HEADER at edge N+1 → header `m_valid` visible after N+1.
- Result latency: a result pushed at edge N is visible on `m_data` after edge N, provided the FSM is in BODY and the FIFO was empty.
- Throughput: one word per cycle in BODY with `m_ready` held high.
- `almost_full` and `busy` are registered and reflect post-edge state.

## Configuration
- `RESULT_CHECKSUM_EN` defined:
  - Adds a TRAILER state after BODY.
  - TRAILER emits the XOR of all body words of the frame (header excluded; 0 for an empty frame).
  - `m_last` moves from the last body word to the trailer.
  - The XOR accumulator clears on entry to HEADER.
- `RESULT_CHECKSUM_EN` undefined: no TRAILER state; `m_last` sits on the last body word (or on the header when count is 0).

## Test plan
- Count 3 pushed; results 0xA, 0xB, 0xC; `m_ready=1` → stream 3, 0xA, 0xB, 0xC, with `m_last` only on 0xC (checksum build: trailer 0xD with `m_last`).
- Count 0 → single header word 0 with `m_last=1`; FSM returns to IDLE; `busy`=0 next cycle.
- `m_ready` held 0 with DEPTH=16 and 17 results pushed → `almost_full` at 12 entries; 17th result dropped; `overflow`=1; the first 16 results emerge intact afterwards.
- Results 0x1, 0x2 pushed before count 2 → frame 2, 0x1, 0x2; `m_data` stable across a 5-cycle `m_ready` stall.
- Two counts (4, then 5) while the first frame is still pending → `frame_error`=1; only the frame of 4 is emitted.
- `clear` pulsed low during BODY with 2 of 4 words sent → outputs 0 immediately; FIFO empty; next count 1 with result 0x55 → frame 1, 0x55.
